decode_execute_register: RTL and testbench

- ID stage decode plus ID/EX pipeline register, directly downstream of register_file.
- Combinationally drives the register file read addresses from the fetched instruction.
- Generates immediates and control, and latches operands and control into the EX stage.
- Detects load-use hazards, obeys EX back-pressure, and handles branch flush.
- WB->ID same-cycle bypass is already done inside register_file and is not repeated here.

---
 rtl/decode_execute_register_if.sv | 40 ++++
 rtl/decode_execute_register.sv | 165 ++++++++++++++++
 tb/tb_decode_execute_register.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_execute_register_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | decode_execute_register_if                                            |
// | ID/EX stage bundle: EX handshake/flush in, latched operands/ctrl out. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface decode_execute_register_if;
  logic        ex_ready_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs1_o;
  logic [4:0]  ex_rs2_o;
  logic [4:0]  ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_funct7b5_o;
  logic [6:0]  ex_opcode_o;
  logic        ex_ctrl_write_back_o;
  logic        ex_ctrl_mem_read_o;
  logic        ex_ctrl_mem_write_o;
  logic        ex_illegal_o;

  modport master (
    input  ex_ready_i, flush_i,
    output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o, ex_opcode_o,
           ex_ctrl_write_back_o, ex_ctrl_mem_read_o, ex_ctrl_mem_write_o, ex_illegal_o
  );

  modport slave (
    output ex_ready_i, flush_i,
    input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o, ex_opcode_o,
           ex_ctrl_write_back_o, ex_ctrl_mem_read_o, ex_ctrl_mem_write_o, ex_illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/decode_execute_register.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | decode_execute_register                                               |
// | RV32 ID decode plus ID/EX register with load-use bubble and flush.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module decode_execute_register #(
  parameter int unsigned REG_ADDR_BITS   = 5,
  parameter bit          LOAD_USE_BUBBLE = 1'b1
) (
  input  wire logic        clk_i,
  input  wire logic        reset_i,
  input  wire logic        instr_valid_i,
  input  wire logic [31:0] instr_i,
  input  wire logic [31:0] pc_i,
  output logic      [4:0]  read_register_1_o,
  output logic      [4:0]  read_register_2_o,
  input  wire logic [31:0] register_data_1_i,
  input  wire logic [31:0] register_data_2_i,
  output logic             stall_o,
  decode_execute_register_if.master ex_if
);

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [6:0]  opcode;
    logic        write_back;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } id_ex_t;

  id_ex_t id_ex_q, id_ex_d, w_dec;
  logic   w_uses_rs1, w_uses_rs2, w_wb, w_mr, w_mw, w_ill;
  logic   w_hold, w_load_use;

  assign read_register_1_o = instr_i[19:15];
  assign read_register_2_o = instr_i[24:20];

  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_wb       = 1'b0;
    w_mr       = 1'b0;
    w_mw       = 1'b0;
    w_ill      = 1'b0;
    w_dec          = '0;
    w_dec.pc       = pc_i;
    w_dec.rs1_data = register_data_1_i;
    w_dec.rs2_data = register_data_2_i;
    w_dec.rs1      = instr_i[19:15];
    w_dec.rs2      = instr_i[24:20];
    w_dec.rd       = instr_i[11:7];
    w_dec.funct3   = instr_i[14:12];
    w_dec.funct7b5 = instr_i[30];
    w_dec.opcode   = instr_i[6:0];
    case (instr_i[6:0])
      c_opc_op: begin
        w_wb = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      c_opc_op_imm, c_opc_jalr: begin
        w_wb = 1'b1; w_uses_rs1 = 1'b1;
        w_dec.imm = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      c_opc_load: begin
        w_wb = 1'b1; w_uses_rs1 = 1'b1; w_mr = 1'b1;
        w_dec.imm = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      c_opc_store: begin
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_mw = 1'b1;
        w_dec.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      c_opc_branch: begin
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        w_dec.imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      c_opc_lui, c_opc_auipc: begin
        w_wb = 1'b1;
        w_dec.imm = {instr_i[31:12], 12'b0};
      end
      c_opc_jal: begin
        w_wb = 1'b1;
        w_dec.imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      default: w_ill = 1'b1;
    endcase
    // Control is gated by slot validity here so EX never sees control on a bubble.
    w_dec.valid      = instr_valid_i;
    w_dec.write_back = instr_valid_i & w_wb & (instr_i[11:7] != 5'd0);
    w_dec.mem_read   = instr_valid_i & w_mr;
    w_dec.mem_write  = instr_valid_i & w_mw;
    w_dec.illegal    = instr_valid_i & w_ill;
  end

  assign w_hold = id_ex_q.valid & ~ex_if.ex_ready_i;

  generate
    if (LOAD_USE_BUBBLE) begin : g_load_use
      logic [REG_ADDR_BITS-1:0] w_ex_rd;
      assign w_ex_rd    = id_ex_q.rd[REG_ADDR_BITS-1:0];
      assign w_load_use = instr_valid_i & id_ex_q.valid & id_ex_q.mem_read & (w_ex_rd != '0) &
                          ((w_uses_rs1 & (instr_i[15 +: REG_ADDR_BITS] == w_ex_rd)) |
                           (w_uses_rs2 & (instr_i[20 +: REG_ADDR_BITS] == w_ex_rd)));
    end else begin : g_no_load_use
      assign w_load_use = 1'b0;
    end
  endgenerate

  assign stall_o = ~ex_if.flush_i & (w_hold | w_load_use);

  always_comb begin
    id_ex_d = id_ex_q;
    if (ex_if.flush_i || (!w_hold && w_load_use)) begin
      id_ex_d.valid      = 1'b0;
      id_ex_d.write_back = 1'b0;
      id_ex_d.mem_read   = 1'b0;
      id_ex_d.mem_write  = 1'b0;
      id_ex_d.illegal    = 1'b0;
    end else if (!w_hold) begin
      id_ex_d = w_dec;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) id_ex_q <= '0;
    else         id_ex_q <= id_ex_d;
  end

  assign ex_if.ex_valid_o           = id_ex_q.valid;
  assign ex_if.ex_pc_o              = id_ex_q.pc;
  assign ex_if.ex_rs1_data_o        = id_ex_q.rs1_data;
  assign ex_if.ex_rs2_data_o        = id_ex_q.rs2_data;
  assign ex_if.ex_imm_o             = id_ex_q.imm;
  assign ex_if.ex_rs1_o             = id_ex_q.rs1;
  assign ex_if.ex_rs2_o             = id_ex_q.rs2;
  assign ex_if.ex_rd_o              = id_ex_q.rd;
  assign ex_if.ex_funct3_o          = id_ex_q.funct3;
  assign ex_if.ex_funct7b5_o        = id_ex_q.funct7b5;
  assign ex_if.ex_opcode_o          = id_ex_q.opcode;
  assign ex_if.ex_ctrl_write_back_o = id_ex_q.write_back;
  assign ex_if.ex_ctrl_mem_read_o   = id_ex_q.mem_read;
  assign ex_if.ex_ctrl_mem_write_o  = id_ex_q.mem_write;
  assign ex_if.ex_illegal_o         = id_ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_register.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_decode_execute_register                                            |
// | Directed scenarios plus random traffic against a behavioural model.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_decode_execute_register;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  op;
    logic        wb, mr, mw, ill;
  } st_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        instr_valid_i;
  logic [31:0] instr_i, pc_i, rd1, rd2;
  logic [4:0]  rr1, rr2;
  logic        stall_o;
  int          tests = 0;
  int          fails = 0;
  st_t         m;

  decode_execute_register_if ex_if();

  decode_execute_register #(.REG_ADDR_BITS(5), .LOAD_USE_BUBBLE(1'b1)) dut (
    .clk_i(clk), .reset_i(reset_i), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .pc_i(pc_i), .read_register_1_o(rr1), .read_register_2_o(rr2),
    .register_data_1_i(rd1), .register_data_2_i(rd2), .stall_o(stall_o), .ex_if(ex_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] t;
    t = $signed(v << (32 - bits));
    t = t >>> (32 - bits);
    return t;
  endfunction

  function automatic st_t model_decode(input logic iv, input logic [31:0] ins,
                                       input logic [31:0] pc, input logic [31:0] a,
                                       input logic [31:0] b);
    st_t s;
    logic wr;
    s = '0;
    s.valid = iv; s.pc = pc; s.d1 = a; s.d2 = b;
    s.rs1 = 5'((ins >> 15) & 31); s.rs2 = 5'((ins >> 20) & 31); s.rd = 5'((ins >> 7) & 31);
    s.f3 = 3'((ins >> 12) & 7); s.f7 = ins[30]; s.op = 7'(ins & 127);
    wr = 1'b0;
    case (s.op)
      7'h33: wr = 1'b1;
      7'h13, 7'h67, 7'h03: begin wr = 1'b1; s.imm = sext(ins >> 20, 12); end
      7'h23: s.imm = sext(((ins >> 25) << 5) | ((ins >> 7) & 31), 12);
      7'h63: s.imm = sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                          (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
      7'h37, 7'h17: begin wr = 1'b1; s.imm = ins & 32'hFFFFF000; end
      7'h6F: begin wr = 1'b1;
        s.imm = sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                     (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
      end
      default: s.ill = iv;
    endcase
    s.wb = iv && wr && (s.rd != 0);
    s.mr = iv && (s.op == 7'h03);
    s.mw = iv && (s.op == 7'h23);
    return s;
  endfunction

  function automatic logic model_load_use();
    logic [6:0] op;
    logic u1, u2;
    op = 7'(instr_i & 127);
    u1 = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) || (op == 7'h63) || (op == 7'h67);
    u2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
    return instr_valid_i && m.valid && m.mr && (m.rd != 0) &&
           ((u1 && (5'((instr_i >> 15) & 31) == m.rd)) || (u2 && (5'((instr_i >> 20) & 31) == m.rd)));
  endfunction

  function automatic logic model_stall();
    return !ex_if.flush_i && ((m.valid && !ex_if.ex_ready_i) || model_load_use());
  endfunction

  function automatic st_t model_next();
    st_t nx;
    logic hold;
    if (reset_i) return '0;
    hold = m.valid && !ex_if.ex_ready_i;
    nx = m;
    if (ex_if.flush_i || (!hold && model_load_use())) begin
      nx.valid = 0; nx.wb = 0; nx.mr = 0; nx.mw = 0; nx.ill = 0;
    end else if (!hold) begin
      nx = model_decode(instr_valid_i, instr_i, pc_i, rd1, rd2);
    end
    return nx;
  endfunction

  function automatic st_t dut_out();
    st_t s;
    s.valid = ex_if.ex_valid_o; s.pc = ex_if.ex_pc_o; s.d1 = ex_if.ex_rs1_data_o;
    s.d2 = ex_if.ex_rs2_data_o; s.imm = ex_if.ex_imm_o; s.rs1 = ex_if.ex_rs1_o;
    s.rs2 = ex_if.ex_rs2_o; s.rd = ex_if.ex_rd_o; s.f3 = ex_if.ex_funct3_o;
    s.f7 = ex_if.ex_funct7b5_o; s.op = ex_if.ex_opcode_o; s.wb = ex_if.ex_ctrl_write_back_o;
    s.mr = ex_if.ex_ctrl_mem_read_o; s.mw = ex_if.ex_ctrl_mem_write_o; s.ill = ex_if.ex_illegal_o;
    return s;
  endfunction

  task automatic tick();
    st_t nx;
    nx = model_next();
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    instr_valid_i = v; instr_i = ins; pc_i = pc;
    rd1 = $urandom; rd2 = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    st_t got;
    reset_i = 1'b1; ex_if.ex_ready_i = 1'b1; ex_if.flush_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'h100);
    #22;
    got = dut_out();
    tests++;
    if (got !== '0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", got); end
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    reset_i = 1'b0;
    m = '0;
  endtask

  task automatic test_decode_latch();
    st_t got;
    drive(1'b1, 32'h00500093, 32'h100);
    #1;
    tests++;
    if (rr1 !== 5'd0 || rr2 !== 5'd5) begin fails++; $display("FAIL read_addr got=%0d,%0d exp=0,5", rr1, rr2); end
    tick();
    got = dut_out();
    tests++;
    if (got.valid !== 1'b1 || got.imm !== 32'd5 || got.rd !== 5'd1 || got.wb !== 1'b1 || got.pc !== 32'h100)
    begin fails++; $display("FAIL addi_latch got v=%b imm=%h rd=%0d wb=%b pc=%h exp 1,5,1,1,100", got.valid, got.imm, got.rd, got.wb, got.pc); end
    tests++;
    if (got !== m) begin fails++; $display("FAIL addi_model got=%h exp=%h", got, m); end
  endtask

  task automatic test_load_use();
    st_t got;
    drive(1'b1, 32'h0000A103, 32'h104);
    tick();
    drive(1'b1, 32'h001101B3, 32'h108);
    #1;
    tests++;
    if (stall_o !== 1'b1) begin fails++; $display("FAIL load_use_stall got=%b exp=1", stall_o); end
    tick();
    tests++;
    if (ex_if.ex_valid_o !== 1'b0 || ex_if.ex_ctrl_write_back_o !== 1'b0 || ex_if.ex_ctrl_mem_read_o !== 1'b0)
    begin fails++; $display("FAIL load_use_bubble got v=%b wb=%b mr=%b exp 0,0,0", ex_if.ex_valid_o, ex_if.ex_ctrl_write_back_o, ex_if.ex_ctrl_mem_read_o); end
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL load_use_release got=%b exp=0", stall_o); end
    rd1 = $urandom; rd2 = $urandom;
    tick();
    got = dut_out();
    tests++;
    if (got.valid !== 1'b1 || got.rs1 !== 5'd2 || got.rs2 !== 5'd1 || got.rd !== 5'd3 || got !== m)
    begin fails++; $display("FAIL add_after_bubble got=%h exp=%h", got, m); end
  endtask

  task automatic test_branch();
    drive(1'b1, 32'hFE000EE3, 32'h200);
    tick();
    tests++;
    if (ex_if.ex_imm_o !== 32'hFFFFFFFC || ex_if.ex_ctrl_write_back_o !== 1'b0 || ex_if.ex_valid_o !== 1'b1)
    begin fails++; $display("FAIL beq_imm got imm=%h wb=%b v=%b exp FFFFFFFC,0,1", ex_if.ex_imm_o, ex_if.ex_ctrl_write_back_o, ex_if.ex_valid_o); end
    drive(1'b1, 32'h00002003, 32'h204);
    tick();
    drive(1'b1, 32'hFE000EE3, 32'h208);
    #1;
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL beq_after_lw_x0 stall got=%b exp=0", stall_o); end
    tick();
    tests++;
    if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_pc_o !== 32'h208)
    begin fails++; $display("FAIL beq_after_lw_x0 latch got v=%b pc=%h exp 1,208", ex_if.ex_valid_o, ex_if.ex_pc_o); end
  endtask

  task automatic test_back_pressure();
    st_t snap, got;
    drive(1'b1, 32'h00A00093, 32'h300);
    tick();
    snap = dut_out();
    ex_if.ex_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, $urandom, 32'h400 + 32'(c));
      #1;
      tests++;
      if (stall_o !== 1'b1) begin fails++; $display("FAIL hold_stall c%0d got=%b exp=1", c, stall_o); end
      tick();
      got = dut_out();
      tests++;
      if (got !== snap) begin fails++; $display("FAIL hold_stable c%0d got=%h exp=%h", c, got, snap); end
    end
    ex_if.flush_i = 1'b1;
    #1;
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    tick();
    tests++;
    if (ex_if.ex_valid_o !== 1'b0 || ex_if.ex_ctrl_write_back_o !== 1'b0 || stall_o !== 1'b0)
    begin fails++; $display("FAIL flush_kill got v=%b wb=%b stall=%b exp 0,0,0", ex_if.ex_valid_o, ex_if.ex_ctrl_write_back_o, stall_o); end
    ex_if.flush_i = 1'b0;
    ex_if.ex_ready_i = 1'b1;
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'hFFFFFFFF, 32'h500);
    tick();
    tests++;
    if (ex_if.ex_illegal_o !== 1'b1 || ex_if.ex_ctrl_write_back_o !== 1'b0 ||
        ex_if.ex_ctrl_mem_read_o !== 1'b0 || ex_if.ex_ctrl_mem_write_o !== 1'b0 || ex_if.ex_imm_o !== 32'd0)
    begin fails++; $display("FAIL illegal got ill=%b wb=%b mr=%b mw=%b imm=%h exp 1,0,0,0,0", ex_if.ex_illegal_o,
      ex_if.ex_ctrl_write_back_o, ex_if.ex_ctrl_mem_read_o, ex_if.ex_ctrl_mem_write_o, ex_if.ex_imm_o); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h00500093, 32'h600);
    tick();
    ex_if.ex_ready_i = 1'b0;
    #1;
    tests++;
    if (stall_o !== 1'b1) begin fails++; $display("FAIL pre_reset_hold got=%b exp=1", stall_o); end
    #1;
    reset_i = 1'b1;
    #1;
    tests++;
    if (ex_if.ex_valid_o !== 1'b0 || stall_o !== 1'b0)
    begin fails++; $display("FAIL async_reset got v=%b stall=%b exp 0,0", ex_if.ex_valid_o, stall_o); end
    #1;
    reset_i = 1'b0;
    m = '0;
    ex_if.ex_ready_i = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0]  pool [12];
    logic [31:0] ins;
    st_t got;
    pool = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F, 7'h00};
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[6:0]   = pool[$urandom_range(0, 11)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 8, ins, $urandom);
      ex_if.ex_ready_i = $urandom_range(0, 3) != 0;
      ex_if.flush_i    = $urandom_range(0, 9) == 0;
      #1;
      tests++;
      if (stall_o !== model_stall() || rr1 !== ins[19:15] || rr2 !== ins[24:20])
      begin fails++; $display("FAIL rand_comb i%0d stall=%b rr=%0d,%0d exp stall=%b rr=%0d,%0d", i, stall_o, rr1, rr2, model_stall(), ins[19:15], ins[24:20]); end
      tick();
      got = dut_out();
      tests++;
      if (m.valid ? (got !== m) : ({got.valid, got.wb, got.mr, got.mw} !== 4'b0000))
      begin fails++; $display("FAIL rand_state i%0d got=%h exp=%h", i, got, m); end
    end
    ex_if.flush_i = 1'b0;
    ex_if.ex_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_decode_latch();
    test_load_use();
    test_branch();
    test_back_pressure();
    test_illegal();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
